// File: rtl/clint_axi_slave_if.sv
// AXI4 read-address / read-data channel bundle for the CLINT timer slave.
// Latency: none, wires only.
// Backpressure: AR uses arvalid/arready and R uses rvalid/rready, each owned by the modports below.
interface clint_axi_slave_if #(
   parameter int ID_W = 4
);
   logic            arvalid;
   logic            arready;
   logic [31:0]     araddr;
   logic [ID_W-1:0] arid;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic [ID_W-1:0] rid;

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/clint_axi_slave.sv
// CLINT mtime counter served as an AXI4 read-only slave (lo word at BASE_ADDR, hi word at BASE_ADDR+4).
// Latency: first R beat 1 cycle after the AR handshake, then one beat per accepted R handshake.
// Backpressure: R beat registers hold while rready is low; AR is refused until the last beat is taken.
// Optional MTIME_SNAPSHOT_EN: a low-word beat captures the high word so a following hi read is tear-free.
module clint_axi_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned DIV       = 1,
   parameter int unsigned ID_W      = 4
) (
   input  logic             clock,
   input  logic             reset,
   clint_axi_slave_if.slave bus
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic {
      IDLE = 1'b0,
      BEAT = 1'b1
   } state_t;

   // Latched AR attributes; addr tracks the address of the beat currently in the R registers.
   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } req_t;

   typedef struct packed {
      logic [31:0] dat;
      logic [1:0]  resp;
   } beat_t;

   state_t          state_q;
   state_t          state_d;

   logic [CNT_W-1:0] pre_q;
   logic             tick;
   logic [63:0]      mtime_q;
   logic [63:0]      mtime_nxt;

   req_t             req_q;
   logic [7:0]       beat_q;
   logic [ID_W-1:0]  rid_q;
   logic [31:0]      rdata_q;
   logic [1:0]       rresp_q;
   logic             rlast_q;

   logic             ar_hs;
   logic             r_hs;
   logic             r_adv;
   logic             load_en;

   logic [31:0]      step_bytes;
   logic [31:0]      adv_addr;
   logic [31:0]      load_addr;
   logic [2:0]       load_size;
   logic [7:0]       load_len;
   logic [7:0]       load_idx;
   logic [31:0]      offset;
   logic [31:0]      hi_word;
   beat_t            beat;

   // ------------------------------------------------------------------
   // mtime and its prescaler
   // ------------------------------------------------------------------
   assign tick      = (pre_q == CNT_MAX);
   assign mtime_nxt = tick ? (mtime_q + 64'd1) : mtime_q;

   // Free-running prescaler and 64-bit timer; wraps silently at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         pre_q   <= '0;
         mtime_q <= '0;
      end else begin
         pre_q   <= tick ? '0 : (pre_q + CNT_W'(1));
         mtime_q <= mtime_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign ar_hs   = (state_q == IDLE) && bus.arvalid;
   assign r_hs    = (state_q == BEAT) && bus.rready;
   assign r_adv   = r_hs && !rlast_q;
   assign load_en = ar_hs || r_adv;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enter BEAT on AR, leave once the last beat is accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.arvalid) state_d = BEAT;
         BEAT:    if (bus.rready && rlast_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      bus.arready = (state_q == IDLE);
      bus.rvalid  = (state_q == BEAT);
   end

   // ------------------------------------------------------------------
   // Beat address and load selection
   // ------------------------------------------------------------------
   // Next beat address; WRAP behaves as INCR since the window is only two words.
   always_comb begin
      step_bytes = 32'd1 << req_q.size;
      adv_addr   = (req_q.burst == BURST_FIXED) ? req_q.addr : (req_q.addr + step_bytes);
   end

   // Pick AR fields for the first beat, latched fields for later beats.
   always_comb begin
      load_addr = ar_hs ? bus.araddr : adv_addr;
      load_size = ar_hs ? bus.arsize : req_q.size;
      load_len  = ar_hs ? bus.arlen  : req_q.len;
      load_idx  = ar_hs ? 8'd0       : (beat_q + 8'd1);
   end

   assign offset = load_addr - BASE_ADDR;

`ifdef MTIME_SNAPSHOT_EN
   logic [31:0] hi_shadow_q;
   logic        lo_hit;

   assign lo_hit  = (load_size <= 3'd2) && (offset < 32'd4);
   assign hi_word = hi_shadow_q;

   // Capture the high word in the same sample as every low-word beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         hi_shadow_q <= '0;
      end else if (load_en && lo_hit) begin
         hi_shadow_q <= mtime_nxt[63:32];
      end
   end
`else
   assign hi_word = mtime_nxt[63:32];
`endif

   // Decode one beat: word 0 is mtime lo, word 1 is mtime hi, anything else (or arsize>2) is DECERR.
   always_comb begin
      beat.dat  = 32'd0;
      beat.resp = RESP_DECERR;
      if (load_size <= 3'd2) begin
         if (offset < 32'd4) begin
            beat.dat  = mtime_nxt[31:0];
            beat.resp = RESP_OKAY;
         end else if (offset < 32'd8) begin
            beat.dat  = hi_word;
            beat.resp = RESP_OKAY;
         end
      end
   end

   // ------------------------------------------------------------------
   // Request latch and R beat registers
   // ------------------------------------------------------------------
   // Latch the request on AR, then advance address/beat and reload R on each non-final R handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         req_q   <= '0;
         beat_q  <= '0;
         rid_q   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rlast_q <= 1'b0;
      end else begin
         if (ar_hs) begin
            req_q <= '{addr: bus.araddr, len: bus.arlen, size: bus.arsize, burst: bus.arburst};
            rid_q <= bus.arid;
         end else if (r_adv) begin
            req_q.addr <= adv_addr;
         end

         if (load_en) begin
            beat_q  <= load_idx;
            rdata_q <= beat.dat;
            rresp_q <= beat.resp;
            rlast_q <= (load_idx == load_len);
         end else if (r_hs) begin
            rlast_q <= 1'b0;
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.rresp = rresp_q;
   assign bus.rlast = rlast_q;
   assign bus.rid   = rid_q;

endmodule

// File: tb/tb_clint_axi_slave.sv
// Directed bench for clint_axi_slave: one DIV=1 instance and one DIV=4 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours MTIME_SNAPSHOT_EN when computing the expected high-word values.
module tb_clint_axi_slave;

   localparam logic [31:0] BASE = 32'h0200_0000;

`ifdef MTIME_SNAPSHOT_EN
   localparam logic [31:0] T2_HI = 32'h0000_0000;
   localparam logic [31:0] T3_HI = 32'h0000_0000;
`else
   localparam logic [31:0] T2_HI = 32'h0000_0001;
   localparam logic [31:0] T3_HI = 32'h0000_0001;
`endif

   logic        clock;
   logic        reset1;
   logic        reset4;
   logic [63:0] cnt1;
   logic [63:0] ofs1;
   logic [63:0] mt;
   int          checks;
   int          failures;

   clint_axi_slave_if #(.ID_W(4)) b1 ();
   clint_axi_slave_if #(.ID_W(4)) b4 ();

   clint_axi_slave #(.BASE_ADDR(BASE), .DIV(1), .ID_W(4)) dut1 (
      .clock (clock),
      .reset (reset1),
      .bus   (b1)
   );

   clint_axi_slave #(.BASE_ADDR(BASE), .DIV(4), .ID_W(4)) dut4 (
      .clock (clock),
      .reset (reset4),
      .bus   (b4)
   );

   always #5 clock = ~clock;

   // Reference count of post-reset edges for the DIV=1 instance.
   always @(posedge clock) begin
      if (reset1) cnt1 <= 64'd0;
      else        cnt1 <= cnt1 + 64'd1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ar1(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] bu, input logic [3:0] id);
      b1.arvalid = 1'b1;
      b1.araddr  = a;
      b1.arlen   = l;
      b1.arsize  = s;
      b1.arburst = bu;
      b1.arid    = id;
   endtask

   task automatic ar4(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] bu, input logic [3:0] id);
      b4.arvalid = 1'b1;
      b4.araddr  = a;
      b4.arlen   = l;
      b4.arsize  = s;
      b4.arburst = bu;
      b4.arid    = id;
   endtask

   initial begin
      logic [31:0] exp_dat [4];
      logic [1:0]  exp_rsp [4];
      logic        pat [10];
      logic [31:0] div_exp [5];
      int          bi;

      clock    = 1'b0;
      reset1   = 1'b1;
      reset4   = 1'b1;
      ofs1     = 64'd0;
      checks   = 0;
      failures = 0;
      b1.arvalid = 1'b0; b1.araddr = '0; b1.arlen = '0; b1.arsize = '0;
      b1.arburst = '0;   b1.arid   = '0; b1.rready = 1'b0;
      b4.arvalid = 1'b0; b4.araddr = '0; b4.arlen = '0; b4.arsize = '0;
      b4.arburst = '0;   b4.arid   = '0; b4.rready = 1'b0;

      step(2);
      chk("rst_arready", b1.arready, 1);
      chk("rst_rvalid",  b1.rvalid,  0);
      chk("rst_rlast",   b1.rlast,   0);
      chk("rst_rdata",   b1.rdata,   0);
      chk("rst_rresp",   b1.rresp,   0);
      chk("rst_rid",     b1.rid,     0);

      // 1: single lo read after 10 idle cycles, with one stall cycle.
      reset1 = 1'b0;
      step(10);
      ar1(BASE, 8'd0, 3'd2, 2'b01, 4'd3);
      b1.rready = 1'b0;
      step(1);
      b1.arvalid = 1'b0;
      chk("t1_rvalid",  b1.rvalid,  1);
      chk("t1_arready", b1.arready, 0);
      chk("t1_rdata",   b1.rdata,   32'd11);
      chk("t1_rresp",   b1.rresp,   2'b00);
      chk("t1_rlast",   b1.rlast,   1);
      chk("t1_rid",     b1.rid,     4'd3);
      step(1);
      chk("t1_hold_rdata",   b1.rdata,   32'd11);
      chk("t1_hold_arready", b1.arready, 0);
      b1.rready = 1'b1;
      step(1);
      chk("t1_done_rvalid",  b1.rvalid,  0);
      chk("t1_done_arready", b1.arready, 1);

      // 2: lo/hi burst across the 32-bit carry.
      force dut1.mtime_q = 64'h0000_0000_FFFF_FFFE;
      release dut1.mtime_q;
      ofs1 = 64'h0000_0000_FFFF_FFFE - cnt1;
      ar1(BASE, 8'd1, 3'd2, 2'b01, 4'd5);
      step(1);
      b1.arvalid = 1'b0;
      chk("t2_b0_rdata", b1.rdata, 32'hFFFF_FFFF);
      chk("t2_b0_rlast", b1.rlast, 0);
      chk("t2_b0_rresp", b1.rresp, 2'b00);
      step(1);
      chk("t2_b1_rdata", b1.rdata, T2_HI);
      chk("t2_b1_rlast", b1.rlast, 1);
      chk("t2_b1_rid",   b1.rid,   4'd5);
      step(1);
      chk("t2_done_rvalid", b1.rvalid, 0);

      // 3: out-of-range word, then the hi word.
      ar1(BASE + 32'h10, 8'd0, 3'd2, 2'b01, 4'd7);
      step(1);
      b1.arvalid = 1'b0;
      chk("t3_bad_rresp", b1.rresp, 2'b11);
      chk("t3_bad_rdata", b1.rdata, 0);
      chk("t3_bad_rlast", b1.rlast, 1);
      chk("t3_bad_rid",   b1.rid,   4'd7);
      step(1);
      ar1(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'd2);
      step(1);
      b1.arvalid = 1'b0;
      chk("t3_hi_rresp", b1.rresp, 2'b00);
      chk("t3_hi_rdata", b1.rdata, T3_HI);
      step(1);

      // 4: 4-beat INCR with stalls; beats 2 and 3 fall outside the window.
      ar1(BASE, 8'd3, 3'd2, 2'b01, 4'd9);
      b1.rready = 1'b0;
      step(1);
      b1.arvalid = 1'b0;
      mt = cnt1 + ofs1;
      exp_dat = '{mt[31:0], 32'd1, 32'd0, 32'd0};
      exp_rsp = '{2'b00, 2'b00, 2'b11, 2'b11};
      pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      bi = 0;
      for (int i = 0; i < 10; i++) begin
         chk("t4_rvalid", b1.rvalid, 1);
         chk("t4_rdata",  b1.rdata,  exp_dat[bi]);
         chk("t4_rresp",  b1.rresp,  exp_rsp[bi]);
         chk("t4_rlast",  b1.rlast,  (bi == 3) ? 1'b1 : 1'b0);
         b1.rready = pat[i];
         step(1);
         if (pat[i]) bi++;
      end
      chk("t4_done_rvalid", b1.rvalid, 0);

      // 5: FIXED burst on the hi word.
      b1.rready = 1'b1;
      ar1(BASE + 32'h4, 8'd2, 3'd2, 2'b00, 4'hA);
      step(1);
      b1.arvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_rdata", b1.rdata, 32'd1);
         chk("t5_rresp", b1.rresp, 2'b00);
         chk("t5_rlast", b1.rlast, (i == 2) ? 1'b1 : 1'b0);
         chk("t5_rid",   b1.rid,   4'hA);
         step(1);
      end
      chk("t5_done_rvalid", b1.rvalid, 0);

      // arsize beyond 4 bytes is answered with DECERR.
      ar1(BASE, 8'd0, 3'd3, 2'b01, 4'd1);
      step(1);
      b1.arvalid = 1'b0;
      chk("sz3_rresp", b1.rresp, 2'b11);
      chk("sz3_rdata", b1.rdata, 0);
      step(1);

      // WRAP behaves as INCR: lo then hi.
      ar1(BASE, 8'd1, 3'd2, 2'b10, 4'd2);
      step(1);
      b1.arvalid = 1'b0;
      mt = cnt1 + ofs1;
      chk("wrap_b0_rdata", b1.rdata, mt[31:0]);
      step(1);
      chk("wrap_b1_rdata", b1.rdata, 32'd1);
      chk("wrap_b1_rresp", b1.rresp, 2'b00);
      chk("wrap_b1_rlast", b1.rlast, 1);
      step(1);

      // 6: DIV=4 instance, single reads two cycles apart.
      reset4 = 1'b0;
      b4.rready = 1'b1;
      div_exp = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
      for (int i = 0; i < 5; i++) begin
         ar4(BASE, 8'd0, 3'd2, 2'b01, 4'(i));
         step(1);
         b4.arvalid = 1'b0;
         chk("t6_div_rdata", b4.rdata, div_exp[i]);
         step(1);
      end

      // Reset in the middle of a 4-beat burst.
      ar4(BASE, 8'd3, 3'd2, 2'b01, 4'd6);
      step(1);
      b4.arvalid = 1'b0;
      chk("t6_b0_rvalid", b4.rvalid, 1);
      chk("t6_b0_rdata",  b4.rdata,  32'd2);
      step(1);
      chk("t6_b1_rvalid", b4.rvalid, 1);
      chk("t6_b1_rlast",  b4.rlast,  0);
      reset4 = 1'b1;
      b4.rready = 1'b0;
      step(1);
      chk("t6_rst_rvalid",  b4.rvalid,  0);
      chk("t6_rst_arready", b4.arready, 1);
      chk("t6_rst_rlast",   b4.rlast,   0);
      chk("t6_rst_rdata",   b4.rdata,   0);
      chk("t6_rst_rid",     b4.rid,     0);
      reset4 = 1'b0;
      ar4(BASE, 8'd0, 3'd2, 2'b01, 4'd5);
      step(1);
      b4.arvalid = 1'b0;
      chk("t6_fresh_rvalid", b4.rvalid, 1);
      chk("t6_fresh_lt4",    (b4.rdata < 32'd4) ? 1'b1 : 1'b0, 1);
      chk("t6_fresh_rdata",  b4.rdata, 32'd0);
      b4.rready = 1'b1;
      step(1);
      chk("t6_fresh_done", b4.rvalid, 0);
      step(2);
      chk("t6_no_residual", b4.rvalid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
